// File: rtl/ps2_key_decoder_pkg.sv
// Shared PS/2 set-2 definitions: prefix bytes, ignored keyboard replies and
// the 2-bit decoder state encodings.
package ps2_key_decoder_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] ascii;
        logic       ext;
        logic       brk;
        logic       rep;
    } ps2_evt_t;

    // Keyboard replies (self-test pass, ack, echo, errors) that carry no key.
    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFF, 8'h00: hit = 1'b1;
            default:                                 hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational set-2 scan code to ASCII table; unmapped codes give 0x00.
module ps2_ascii_rom (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61;
            8'h32: ascii = 8'h62;
            8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;
            8'h24: ascii = 8'h65;
            8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;
            8'h33: ascii = 8'h68;
            8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;
            8'h42: ascii = 8'h6B;
            8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;
            8'h31: ascii = 8'h6E;
            8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;
            8'h15: ascii = 8'h71;
            8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;
            8'h2C: ascii = 8'h74;
            8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;
            8'h1D: ascii = 8'h77;
            8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;
            8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            8'h66: ascii = 8'h08;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 scan bytes into make/break key events and tracks the
// currently held key plus a count of fresh key presses.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             code_valid,
    input  logic [7:0]       code,
    output logic             code_ready,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic [7:0]       evt_ascii,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic             key_down,
    output logic [7:0]       cur_code,
    output logic             cur_ext,
    output logic [CNT_W-1:0] press_count
);

    logic [1:0] state;
    logic [1:0] next_state;
    logic       accept;
    logic       emit;
    logic       seq_ext;
    logic       seq_brk;
    logic       held_match;
    logic [7:0] rom_ascii;
    ps2_evt_t   next_evt;

    // Every byte, prefixes included, waits behind an unconsumed event.
    assign code_ready = !evt_valid || evt_ready;
    assign accept     = code_valid && code_ready;

    always_comb begin
        next_state = state;
        emit       = 1'b0;
        seq_ext    = 1'b0;
        seq_brk    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (code == PS2_EXT)       next_state = ST_EXT;
                else if (code == PS2_BRK)  next_state = ST_BRK;
                else if (!is_ignored(code)) emit      = 1'b1;
            end
            ST_EXT: begin
                if (code == PS2_BRK)      next_state = ST_EXT_BRK;
                else if (code == PS2_EXT) next_state = ST_EXT;
                else begin
                    emit       = 1'b1;
                    seq_ext    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_BRK: begin
                if (code == PS2_EXT)      next_state = ST_EXT;
                else if (code == PS2_BRK) next_state = ST_BRK;
                else begin
                    emit       = 1'b1;
                    seq_brk    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_EXT_BRK: begin
                next_state = ST_IDLE;
                if (code != PS2_EXT && code != PS2_BRK) begin
                    emit    = 1'b1;
                    seq_ext = 1'b1;
                    seq_brk = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    ps2_ascii_rom u_ascii_rom (
        .code  (code),
        .ascii (rom_ascii)
    );

    assign held_match = key_down && (cur_ext == seq_ext) && (cur_code == code);

    always_comb begin
        next_evt.code  = code;
        next_evt.ascii = seq_ext ? 8'h00 : rom_ascii;
        next_evt.ext   = seq_ext;
        next_evt.brk   = seq_brk;
        next_evt.rep   = !seq_brk && held_match;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else if (accept) begin
            state <= next_state;
        end
    end

    // A completing byte overwrites the register even while it is being consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            evt_valid  <= 1'b0;
            evt_code   <= 8'h00;
            evt_ascii  <= 8'h00;
            evt_ext    <= 1'b0;
            evt_break  <= 1'b0;
            evt_repeat <= 1'b0;
        end else if (accept && emit) begin
            evt_valid  <= 1'b1;
            evt_code   <= next_evt.code;
            evt_ascii  <= next_evt.ascii;
            evt_ext    <= next_evt.ext;
            evt_break  <= next_evt.brk;
            evt_repeat <= next_evt.rep;
        end else if (evt_ready) begin
            evt_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_down    <= 1'b0;
            cur_code    <= 8'h00;
            cur_ext     <= 1'b0;
            press_count <= '0;
        end else if (accept && emit) begin
            if (seq_brk) begin
                if (cur_ext == seq_ext && cur_code == code) key_down <= 1'b0;
            end else if (!held_match) begin
                key_down    <= 1'b1;
                cur_code    <= code;
                cur_ext     <= seq_ext;
                press_count <= press_count + CNT_W'(1);
            end
        end
    end

endmodule
